// File: rtl/mips_dbus_pkg.sv
// Shared encodings for the MIPS data-bus Wishbone master: access sizes, cycle types, FSM states.
package mips_dbus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSingle = 2'd1,
        StBurst  = 2'd2
    } state_e;

endpackage

// File: rtl/dbus_lane_align.sv
// Little-endian byte-lane steering: select generation, store replication, load extraction and
// sign/zero extension, plus alignment checking for single accesses.
module dbus_lane_align
    import mips_dbus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    input  logic        uns_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        case (addr_i)
            2'd0:    rd_byte = rdata_i[7:0];
            2'd1:    rd_byte = rdata_i[15:8];
            2'd2:    rd_byte = rdata_i[23:16];
            default: rd_byte = rdata_i[31:24];
        endcase
        rd_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SZ_BYTE: begin
                sel_o      = 4'b0001 << addr_i;
                wdata_o    = {4{wdata_i[7:0]}};
                rdata_o    = {{24{~uns_i & rd_byte[7]}}, rd_byte};
                misalign_o = 1'b0;
            end
            SZ_HALF: begin
                sel_o      = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = {{16{~uns_i & rd_half[15]}}, rd_half};
                misalign_o = addr_i[0];
            end
            SZ_WORD: begin
                sel_o      = 4'b1111;
                wdata_o    = wdata_i;
                rdata_o    = rdata_i;
                misalign_o = |addr_i;
            end
            default: begin
                // Reserved size: never reaches the bus.
                sel_o      = 4'b0000;
                wdata_o    = wdata_i;
                rdata_o    = rdata_i;
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_dbus_wb_master.sv
// Wishbone B3 data-bus master for the MIPS core: single loads/stores with lane steering and
// extension, incrementing read bursts for line fills, and a no-ack timeout.
module mips_dbus_wb_master
    import mips_dbus_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic        burst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic [3:0]  rbeat_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    input  logic        wb_ack_i
);

    localparam logic [3:0] LastBeat = 4'(BURST_LEN - 1);
    localparam logic [7:0] TmoLast  = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [3:0]  beat_q;
    logic [7:0]  tmo_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        uns_q;

    logic        in_idle;
    logic        want_burst;
    logic        req_bad;
    logic [1:0]  al_size;
    logic [1:0]  al_lane;
    logic        al_uns;
    logic        al_misalign;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    // The aligner sees the incoming request while idle and the latched request while active,
    // so one instance serves both store steering and load extension.
    always_comb begin
        in_idle    = (state_q == StIdle);
        al_size    = in_idle ? size_i : size_q;
        al_lane    = in_idle ? addr_i[1:0] : lane_q;
        al_uns     = in_idle ? uns_i : uns_q;
        want_burst = burst_i & ~we_i;
        if (size_i == SZ_RSVD) begin
            req_bad = 1'b1;
        end else if (want_burst) begin
            req_bad = (addr_i[1:0] != 2'b00) || (size_i != SZ_WORD);
        end else begin
            req_bad = al_misalign;
        end
    end

    dbus_lane_align u_align (
        .size_i     (al_size),
        .addr_i     (al_lane),
        .wdata_i    (wdata_i),
        .rdata_i    (wb_dat_i),
        .uns_i      (al_uns),
        .sel_o      (al_sel),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            tmo_q    <= '0;
            size_q   <= '0;
            lane_q   <= '0;
            uns_q    <= 1'b0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            rbeat_o  <= '0;
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cti_o <= CTI_CLASSIC;
        end else begin
            err_o    <= 1'b0;
            rvalid_o <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_i && req_bad) begin
                        err_o <= 1'b1;
                    end else if (req_i) begin
                        wb_adr_o <= {addr_i[31:2], 2'b00};
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        busy_o   <= 1'b1;
                        tmo_q    <= '0;
                        beat_q   <= '0;
                        size_q   <= size_i;
                        lane_q   <= addr_i[1:0];
                        uns_q    <= uns_i;
                        if (want_burst) begin
                            wb_we_o  <= 1'b0;
                            wb_sel_o <= 4'b1111;
                            wb_cti_o <= CTI_INCR;
                            state_q  <= StBurst;
                        end else begin
                            wb_we_o  <= we_i;
                            wb_sel_o <= al_sel;
                            wb_dat_o <= al_wdata;
                            wb_cti_o <= CTI_CLASSIC;
                            state_q  <= StSingle;
                        end
                    end
                end
                StSingle, StBurst: begin
                    if (wb_ack_i) begin
                        tmo_q <= '0;
                        // stb drops right after the final ack so the slave cannot re-ack.
                        if (state_q == StSingle || beat_q == LastBeat) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            busy_o   <= 1'b0;
                            state_q  <= StIdle;
                        end
                        if (state_q == StSingle) begin
                            if (!wb_we_o) begin
                                rdata_o  <= al_rdata;
                                rvalid_o <= 1'b1;
                                rbeat_o  <= '0;
                            end
                        end else begin
                            rdata_o  <= wb_dat_i;
                            rvalid_o <= 1'b1;
                            rbeat_o  <= beat_q;
                            if (beat_q != LastBeat) begin
                                beat_q   <= beat_q + 4'd1;
                                wb_adr_o <= wb_adr_o + 32'd4;
                                wb_cti_o <= (beat_q + 4'd1 == LastBeat) ? CTI_END : CTI_INCR;
                            end
                        end
                    end else if (tmo_q == TmoLast) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        busy_o   <= 1'b0;
                        err_o    <= 1'b1;
                        tmo_q    <= '0;
                        state_q  <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dbus_wb_master.sv
// Bench for mips_dbus_wb_master: directed scenarios plus randomized traffic against a
// registered-ack RAM slave and an arithmetic reference model of memory and lane rules.
module tb_mips_dbus_wb_master;

    localparam int unsigned BurstLen = 4;
    localparam int unsigned Timeout  = 8;

    typedef logic [31:0] wq_t[$];

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i, we_i, uns_i, burst_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata_o;
    logic        rvalid_o, busy_o, err_o;
    logic [3:0]  rbeat_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;

    always #5 clk_i = ~clk_i;

    mips_dbus_wb_master #(
        .BURST_LEN (BurstLen),
        .TIMEOUT   (Timeout)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .size_i   (size_i),
        .uns_i    (uns_i),
        .burst_i  (burst_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .rbeat_o  (rbeat_o),
        .busy_o   (busy_o),
        .err_o    (err_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_cti_o (wb_cti_o),
        .wb_ack_i (wb_ack_i)
    );

    // Registered-ack RAM slave; streams incrementing bursts with back-to-back acks.
    logic [31:0] mem      [4096];
    logic [31:0] init_mem [4096];
    logic [31:0] ref_mem  [4096];
    logic        s_ack;
    logic [31:0] s_dat;
    logic [1:0]  s_stall;
    logic        slv_rand, slv_noack, mem_load;
    logic [11:0] s_idx;

    assign s_idx    = s_ack ? wb_adr_o[13:2] + 12'd1 : wb_adr_o[13:2];
    assign wb_ack_i = s_ack;
    assign wb_dat_i = s_dat;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_ack   <= 1'b0;
            s_stall <= 2'd0;
            s_dat   <= '0;
            if (mem_load) mem <= init_mem;
        end else if (wb_cyc_o && wb_stb_o && !slv_noack && (!s_ack || wb_cti_o == 3'b010)) begin
            if (slv_rand && s_stall < 2'd2 && $urandom_range(0, 2) == 0) begin
                s_ack   <= 1'b0;
                s_stall <= s_stall + 2'd1;
            end else begin
                s_ack   <= 1'b1;
                s_stall <= 2'd0;
                s_dat   <= mem[s_idx];
                if (wb_we_o) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wb_sel_o[i]) mem[s_idx][8*i +: 8] <= wb_dat_o[8*i +: 8];
                    end
                end
            end
        end else begin
            s_ack <= 1'b0;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input wq_t q, input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    // Reference model rules.
    function automatic logic req_invalid(input logic we, input logic [1:0] sz, input logic bu,
                                         input logic [31:0] ad);
        if (sz == 2'b11) return 1'b1;
        if (bu && !we) return (ad[1:0] != 2'b00) || (sz != 2'b10);
        if (sz == 2'b01) return ad[0];
        if (sz == 2'b10) return ad[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                             input logic un, input logic [1:0] k);
        logic [31:0] v;
        v = w >> (32'(k) * 8);
        if (sz == 2'b00) begin
            v = v & 32'hFF;
            if (!un && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = v & 32'hFFFF;
            if (!un && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] sz, input logic [1:0] k);
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        if (nbytes(sz) < 4) m = (32'd1 << (8 * nbytes(sz))) - 32'd1;
        return m << (32'(k) * 8);
    endfunction

    function automatic logic [3:0] exp_sel(input logic [1:0] sz, input logic [1:0] k);
        return 4'(((1 << nbytes(sz)) - 1) << k);
    endfunction

    // Observations from the most recent transaction.
    int  o_err, err_k, n_cyc, n_busy, rv_k;
    wq_t rv_data, rv_beat, ack_adr, ack_cti, ack_sel, ack_we, ack_dat;

    task automatic xact(input logic we, input logic [1:0] sz, input logic un, input logic bu,
                        input logic [31:0] ad, input logic [31:0] wd);
        int k;
        rv_data.delete(); rv_beat.delete(); ack_adr.delete(); ack_cti.delete();
        ack_sel.delete(); ack_we.delete(); ack_dat.delete();
        o_err = 0; err_k = 0; n_cyc = 0; n_busy = 0; rv_k = 0;
        we_i = we; size_i = sz; uns_i = un; burst_i = bu; addr_i = ad; wdata_i = wd;
        req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        k = 1;
        forever begin
            if (err_o) begin o_err++; err_k = k; end
            if (wb_cyc_o) n_cyc++;
            if (busy_o) n_busy++;
            if (rvalid_o) begin
                rv_data.push_back(rdata_o);
                rv_beat.push_back(32'(rbeat_o));
                if (rv_k == 0) rv_k = k;
            end
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                ack_adr.push_back(wb_adr_o);
                ack_cti.push_back(32'(wb_cti_o));
                ack_sel.push_back(32'(wb_sel_o));
                ack_we.push_back(32'(wb_we_o));
                ack_dat.push_back(wb_dat_o);
            end
            if (!busy_o || k >= 60) break;
            @(negedge clk_i);
            k++;
        end
        chk("busy_bounded", 32'(busy_o), 32'd0);
    endtask

    // Runs one request and checks it entirely against the reference model.
    task automatic run_and_check(input logic we, input logic [1:0] sz, input logic un,
                                 input logic bu, input logic [31:0] ad, input logic [31:0] wd);
        logic [11:0] wi;
        logic [31:0] m, w;
        xact(we, sz, un, bu, ad, wd);
        wi = ad[13:2];
        if (req_invalid(we, sz, bu, ad)) begin
            chk("rej_err", 32'(o_err), 32'd1);
            chk("rej_cyc", 32'(n_cyc), 32'd0);
            chk("rej_busy", 32'(n_busy), 32'd0);
        end else begin
            chk("ok_err", 32'(o_err), 32'd0);
            if (bu && !we) begin
                chk("bst_n", 32'(rv_data.size()), 32'(BurstLen));
                for (int i = 0; i < int'(BurstLen); i++) begin
                    chk("bst_dat", q_at(rv_data, i), ref_mem[wi + 12'(i)]);
                    chk("bst_beat", q_at(rv_beat, i), 32'(i));
                end
            end else if (we) begin
                m = lane_mask(sz, ad[1:0]);
                chk("st_acks", 32'(ack_sel.size()), 32'd1);
                chk("st_sel", q_at(ack_sel, 0), 32'(exp_sel(sz, ad[1:0])));
                chk("st_dat", q_at(ack_dat, 0) & m, (wd << (32'(ad[1:0]) * 8)) & m);
                chk("st_rv", 32'(rv_data.size()), 32'd0);
                w = ref_mem[wi];
                for (int i = 0; i < nbytes(sz); i++) w[8*(int'(ad[1:0]) + i) +: 8] = wd[8*i +: 8];
                ref_mem[wi] = w;
            end else begin
                chk("ld_n", 32'(rv_data.size()), 32'd1);
                chk("ld_dat", q_at(rv_data, 0), load_val(ref_mem[wi], sz, un, ad[1:0]));
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdata"}, rdata_o, 32'd0);
        chk({tag, "_flags"}, 32'({rvalid_o, busy_o, err_o, wb_we_o, wb_cyc_o, wb_stb_o}), 32'd0);
        chk({tag, "_adr"}, wb_adr_o, 32'd0);
        chk({tag, "_dat"}, wb_dat_o, 32'd0);
        chk({tag, "_sel_cti_beat"}, 32'({wb_sel_o, wb_cti_o, rbeat_o}), 32'd0);
    endtask

    initial begin
        logic        we, un, bu;
        logic [1:0]  sz;
        logic [31:0] ad, wd, w;

        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; uns_i = 1'b0;
        burst_i = 1'b0; addr_i = '0; wdata_i = '0;
        slv_rand = 1'b0; slv_noack = 1'b0; mem_load = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            w = $urandom;
            init_mem[i] = w;
            ref_mem[i]  = w;
        end
        init_mem[12'h400] = 32'h80FF_1234;
        ref_mem[12'h400]  = 32'h80FF_1234;

        repeat (3) @(negedge clk_i);
        chk_zero("reset");
        rst_i = 1'b0;
        mem_load = 1'b0;
        @(negedge clk_i);

        // Signed and unsigned half load from the upper half.
        xact(1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_1002, 32'd0);
        chk("lh_sel", q_at(ack_sel, 0), 32'hC);
        chk("lh_we", q_at(ack_we, 0), 32'd0);
        chk("lh_data", q_at(rv_data, 0), 32'hFFFF_80FF);
        chk("lh_rv_lat", 32'(rv_k), 32'd3);
        chk("lh_beat", q_at(rv_beat, 0), 32'd0);
        chk("lh_busy", 32'(n_busy), 32'd2);
        xact(1'b0, 2'b01, 1'b1, 1'b0, 32'h0000_1002, 32'd0);
        chk("lhu_data", q_at(rv_data, 0), 32'h0000_80FF);

        // Byte store into lane 3, then read it back.
        xact(1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_1003, 32'h0000_00A5);
        chk("sb_acks", 32'(ack_sel.size()), 32'd1);
        chk("sb_sel", q_at(ack_sel, 0), 32'h8);
        chk("sb_lane", q_at(ack_dat, 0) >> 24, 32'hA5);
        chk("sb_we", q_at(ack_we, 0), 32'd1);
        chk("sb_cti", q_at(ack_cti, 0), 32'd0);
        chk("sb_busy", 32'(n_busy), 32'd2);
        chk("sb_cyc_end", 32'(wb_cyc_o), 32'd0);
        chk("sb_no_rv", 32'(rv_data.size()), 32'd0);
        ref_mem[12'h400] = 32'hA5FF_1234;
        xact(1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_1003, 32'd0);
        chk("lb_data", q_at(rv_data, 0), 32'hFFFF_FFA5);

        // Four-beat burst with back-to-back acks.
        xact(1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_2000, 32'd0);
        chk("bst_nack", 32'(ack_adr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("bst_adr", q_at(ack_adr, i), 32'h2000 + 32'(4 * i));
            chk("bst_cti", q_at(ack_cti, i), (i == 3) ? 32'd7 : 32'd2);
            chk("bst_rdat", q_at(rv_data, i), ref_mem[12'h800 + 12'(i)]);
            chk("bst_rbeat", q_at(rv_beat, i), 32'(i));
        end
        chk("bst_sel", q_at(ack_sel, 0), 32'hF);
        chk("bst_cyc_end", 32'(wb_cyc_o), 32'd0);

        // Rejected requests never touch the bus.
        xact(1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_1001, 32'd0);
        chk("mis_err", 32'(o_err), 32'd1);
        chk("mis_err_lat", 32'(err_k), 32'd1);
        chk("mis_cyc", 32'(n_cyc), 32'd0);
        chk("mis_busy", 32'(n_busy), 32'd0);
        run_and_check(1'b0, 2'b11, 1'b0, 1'b0, 32'h0000_1000, 32'd0);
        run_and_check(1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_2002, 32'd0);
        run_and_check(1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_1005, 32'd0);

        // Slave that never acks.
        slv_noack = 1'b1;
        xact(1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_1004, 32'd0);
        chk("tmo_cyc", 32'(n_cyc), 32'(Timeout));
        chk("tmo_err", 32'(o_err), 32'd1);
        chk("tmo_err_at", 32'(err_k), 32'(Timeout + 1));
        chk("tmo_no_rv", 32'(rv_data.size()), 32'd0);
        slv_noack = 1'b0;

        // Asynchronous reset while beat 2 of a burst is outstanding.
        we_i = 1'b0; size_i = 2'b10; burst_i = 1'b1; addr_i = 32'h0000_2040; req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0; burst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rstb_adr", wb_adr_o, 32'h0000_2048);
        chk("rstb_rbeat", 32'(rbeat_o), 32'd1);
        #2 rst_i = 1'b1;
        #1 chk_zero("rst_mid");
        @(negedge clk_i);
        chk_zero("rst_hold");
        rst_i = 1'b0;
        @(negedge clk_i);
        run_and_check(1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_2048, 32'd0);
        run_and_check(1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_2040, 32'd0);

        // Randomized traffic with slave wait states.
        slv_rand = 1'b1;
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1));
            bu = ($urandom_range(0, 3) == 0);
            ad = 32'($urandom_range(0, 16383));
            wd = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (bu && !we) sz = 2'b10;
                else if (sz == 2'b11) sz = 2'($urandom_range(0, 2));
                if (sz == 2'b01) ad[0] = 1'b0;
                if (sz == 2'b10) ad[1:0] = 2'b00;
            end
            run_and_check(we, sz, un, bu, ad, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
